// File: rtl/serial_frame_deserializer_if.sv
// Bit-stream input and frame-word output bundle for serial_frame_deserializer.
// The slave modport is the deserializer side; master is the upstream/consumer side.
interface serial_frame_deserializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  Enable_In;
  logic                  Shift_Data_Signal_In;
  logic                  Serial_Data_In;
  logic [DATA_WIDTH-1:0] Parallel_Data_Out;
  logic                  Data_Valid_Out;
  logic                  Data_Ready_In;
  logic                  Sync_Locked_Out;
  logic                  Overrun_Out;
  logic [7:0]            Frame_Count_Out;

  modport slave (
    input  Enable_In, Shift_Data_Signal_In, Serial_Data_In, Data_Ready_In,
    output Parallel_Data_Out, Data_Valid_Out, Sync_Locked_Out, Overrun_Out, Frame_Count_Out
  );

  modport master (
    output Enable_In, Shift_Data_Signal_In, Serial_Data_In, Data_Ready_In,
    input  Parallel_Data_Out, Data_Valid_Out, Sync_Locked_Out, Overrun_Out, Frame_Count_Out
  );
endinterface

// File: rtl/serial_frame_deserializer.sv
// Hunts a sync pattern in a strobed serial stream, collects the following payload
// MSB-first and presents it on a one-deep valid/ready register with overrun flag.
module serial_frame_deserializer #(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    SYNC_WIDTH   = 4,
  parameter logic [SYNC_WIDTH-1:0] SYNC_PATTERN = 4'b1011
) (
  input  logic Clk_In,
  input  logic Reset_In,
  serial_frame_deserializer_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [0:0] {HUNT, COLLECT} state_t;

  state_t                state_q;
  logic [SYNC_WIDTH-1:0] window_q;
  logic [DATA_WIDTH-1:0] data_sr_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [DATA_WIDTH-1:0] pdata_q;
  logic                  valid_q;
  logic                  locked_q;
  logic                  overrun_q;
  logic [7:0]            fcnt_q;

  logic                  accept;
  logic                  drain;
  logic [SYNC_WIDTH-1:0] window_d;
  logic [DATA_WIDTH-1:0] data_sr_d;
  logic                  last_bit;

  always_comb begin
    accept    = bus.Enable_In & bus.Shift_Data_Signal_In;
    drain     = valid_q & bus.Data_Ready_In;
    window_d  = {window_q[SYNC_WIDTH-2:0], bus.Serial_Data_In};
    data_sr_d = {data_sr_q[DATA_WIDTH-2:0], bus.Serial_Data_In};
    last_bit  = (bit_cnt_q == CNT_W'(DATA_WIDTH - 1));
  end

  always_ff @(posedge Clk_In) begin
    if (!Reset_In) begin
      state_q   <= HUNT;
      window_q  <= '0;
      data_sr_q <= '0;
      bit_cnt_q <= '0;
      pdata_q   <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      overrun_q <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      // A load in the same cycle below overrides this clear.
      if (drain) begin
        valid_q <= 1'b0;
      end
      if (accept) begin
        case (state_q)
          HUNT: begin
            window_q <= window_d;
            if (window_d == SYNC_PATTERN) begin
              state_q   <= COLLECT;
              bit_cnt_q <= '0;
              locked_q  <= 1'b1;
            end
          end
          COLLECT: begin
            data_sr_q <= data_sr_d;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (last_bit) begin
              state_q   <= HUNT;
              window_q  <= '0;
              bit_cnt_q <= '0;
              locked_q  <= 1'b0;
              if (!valid_q || drain) begin
                pdata_q <= data_sr_d;
                valid_q <= 1'b1;
                fcnt_q  <= fcnt_q + 8'd1;
              end else begin
                overrun_q <= 1'b1;
              end
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign bus.Parallel_Data_Out = pdata_q;
  assign bus.Data_Valid_Out    = valid_q;
  assign bus.Sync_Locked_Out   = locked_q;
  assign bus.Overrun_Out       = overrun_q;
  assign bus.Frame_Count_Out   = fcnt_q;

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Directed bench for serial_frame_deserializer: one task per scenario with
// hand-computed expectations checked 1 time unit after the sampling edge.
module tb_serial_frame_deserializer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  serial_frame_deserializer_if #(.DATA_WIDTH(8)) bus ();

  serial_frame_deserializer #(
    .DATA_WIDTH  (8),
    .SYNC_WIDTH  (4),
    .SYNC_PATTERN(4'b1011)
  ) dut (
    .Clk_In  (clk),
    .Reset_In(rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.Shift_Data_Signal_In = 1'b0;
    bus.Data_Ready_In = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Drive one strobe with an optional ready in the same cycle.
  task automatic send_bit(input logic b, input logic r);
    @(negedge clk);
    bus.Shift_Data_Signal_In = 1'b1;
    bus.Serial_Data_In       = b;
    bus.Data_Ready_In        = r;
    @(posedge clk);
    #1;
    bus.Shift_Data_Signal_In = 1'b0;
    bus.Data_Ready_In        = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] w, input logic r_last);
    logic [3:0] s;
    s = 4'b1011;
    for (int i = 3; i >= 0; i--) send_bit(s[i], 1'b0);
    for (int i = 7; i >= 1; i--) send_bit(w[i], 1'b0);
    send_bit(w[0], r_last);
  endtask

  task automatic pulse_ready();
    @(negedge clk);
    bus.Data_Ready_In = 1'b1;
    @(posedge clk);
    #1;
    bus.Data_Ready_In = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.Enable_In = 1'b1;
    bus.Shift_Data_Signal_In = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.Serial_Data_In = (i == 0);
      @(negedge clk);
    end
    bus.Shift_Data_Signal_In = 1'b0;
    chk("reset_valid",  32'(bus.Data_Valid_Out), 32'h0);
    chk("reset_data",   32'(bus.Parallel_Data_Out), 32'h0);
    chk("reset_locked", 32'(bus.Sync_Locked_Out), 32'h0);
    chk("reset_ovr",    32'(bus.Overrun_Out), 32'h0);
    chk("reset_count",  32'(bus.Frame_Count_Out), 32'h0);
    rst_n = 1'b1;
    // Had "10" leaked into the window, "11" would complete 1011.
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("reset_no_accept", 32'(bus.Sync_Locked_Out), 32'h0);
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [7:0] w;
    do_reset();
    w = 8'hA5;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("basic_prelock", 32'(bus.Sync_Locked_Out), 32'h0);
    send_bit(1'b1, 1'b0);
    chk("basic_lock", 32'(bus.Sync_Locked_Out), 32'h1);
    for (int i = 7; i >= 1; i--) send_bit(w[i], 1'b0);
    chk("basic_not_yet_valid", 32'(bus.Data_Valid_Out), 32'h0);
    send_bit(w[0], 1'b0);
    chk("basic_valid",  32'(bus.Data_Valid_Out), 32'h1);
    chk("basic_data",   32'(bus.Parallel_Data_Out), 32'hA5);
    chk("basic_count",  32'(bus.Frame_Count_Out), 32'h1);
    chk("basic_unlock", 32'(bus.Sync_Locked_Out), 32'h0);
    pulse_ready();
    chk("basic_drained", 32'(bus.Data_Valid_Out), 32'h0);
    chk("basic_hold",    32'(bus.Parallel_Data_Out), 32'hA5);
    $display("test_basic: data=%h count=%0d", bus.Parallel_Data_Out, bus.Frame_Count_Out);
  endtask

  task automatic test_sliding();
    logic [4:0] pre;
    logic [7:0] w;
    do_reset();
    pre = 5'b11011;
    w   = 8'h3C;
    for (int i = 4; i >= 1; i--) begin
      send_bit(pre[i], 1'b0);
      chk("slide_no_early_lock", 32'(bus.Sync_Locked_Out), 32'h0);
    end
    send_bit(pre[0], 1'b0);
    chk("slide_lock", 32'(bus.Sync_Locked_Out), 32'h1);
    for (int i = 7; i >= 0; i--) send_bit(w[i], 1'b0);
    chk("slide_valid", 32'(bus.Data_Valid_Out), 32'h1);
    chk("slide_data",  32'(bus.Parallel_Data_Out), 32'h3C);
    $display("test_sliding: data=%h", bus.Parallel_Data_Out);
  endtask

  task automatic test_overrun();
    do_reset();
    send_frame(8'hA5, 1'b0);
    chk("ovr_first_clear", 32'(bus.Overrun_Out), 32'h0);
    send_frame(8'h3C, 1'b0);
    chk("ovr_data",  32'(bus.Parallel_Data_Out), 32'hA5);
    chk("ovr_count", 32'(bus.Frame_Count_Out), 32'h1);
    chk("ovr_flag",  32'(bus.Overrun_Out), 32'h1);
    chk("ovr_valid", 32'(bus.Data_Valid_Out), 32'h1);
    pulse_ready();
    chk("ovr_drained", 32'(bus.Data_Valid_Out), 32'h0);
    chk("ovr_sticky",  32'(bus.Overrun_Out), 32'h1);
    $display("test_overrun: overrun=%b count=%0d", bus.Overrun_Out, bus.Frame_Count_Out);
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_frame(8'hA5, 1'b0);
    send_frame(8'h3C, 1'b1);
    chk("b2b_valid", 32'(bus.Data_Valid_Out), 32'h1);
    chk("b2b_data",  32'(bus.Parallel_Data_Out), 32'h3C);
    chk("b2b_count", 32'(bus.Frame_Count_Out), 32'h2);
    chk("b2b_ovr",   32'(bus.Overrun_Out), 32'h0);
    $display("test_back_to_back: data=%h count=%0d", bus.Parallel_Data_Out, bus.Frame_Count_Out);
  endtask

  task automatic test_gating();
    do_reset();
    bus.Enable_In = 1'b0;
    send_frame(8'hA5, 1'b0);
    chk("gate_locked", 32'(bus.Sync_Locked_Out), 32'h0);
    chk("gate_valid",  32'(bus.Data_Valid_Out), 32'h0);
    chk("gate_count",  32'(bus.Frame_Count_Out), 32'h0);
    bus.Enable_In = 1'b1;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("gate_midframe_locked", 32'(bus.Sync_Locked_Out), 32'h1);
    do_reset();
    chk("gate_rst_locked", 32'(bus.Sync_Locked_Out), 32'h0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("gate_no_word",  32'(bus.Data_Valid_Out), 32'h0);
    chk("gate_no_lock",  32'(bus.Sync_Locked_Out), 32'h0);
    chk("gate_count0",   32'(bus.Frame_Count_Out), 32'h0);
    // Handshake must still work with the bit path disabled.
    do_reset();
    send_frame(8'h5A, 1'b0);
    bus.Enable_In = 1'b0;
    pulse_ready();
    chk("gate_handshake", 32'(bus.Data_Valid_Out), 32'h0);
    bus.Enable_In = 1'b1;
    $display("test_gating: valid=%b count=%0d", bus.Data_Valid_Out, bus.Frame_Count_Out);
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 255; i++) send_frame(8'(i), 1'b1);
    chk("wrap_255",  32'(bus.Frame_Count_Out), 32'd255);
    chk("wrap_data", 32'(bus.Parallel_Data_Out), 32'hFE);
    send_frame(8'hC3, 1'b1);
    chk("wrap_0", 32'(bus.Frame_Count_Out), 32'd0);
    $display("test_wrap: count=%0d", bus.Frame_Count_Out);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b1;
    bus.Enable_In = 1'b1;
    bus.Shift_Data_Signal_In = 1'b0;
    bus.Serial_Data_In = 1'b0;
    bus.Data_Ready_In = 1'b0;
    test_reset();
    test_basic();
    test_sliding();
    test_overrun();
    test_back_to_back();
    test_gating();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
